// File: rtl/writeback_queue.sv
// Purpose: selects the writeback result, aligns/extends load data and queues register-file writes.
// Latency: an accepted write is presented on write_* one cycle later; no input-to-output passthrough.
// Backpressure: in_ready drops while the queue is full; write_ack cannot reopen it in the same cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready MEM-stage handshake; in_reg_write/in_rd/in_src pick destination and source
//   in_alu/in_mem/in_pc/in_imm  candidate result values
//   in_msize/in_munsigned/in_boff  load size, extension mode and little-endian byte offset
//   write_en/write_addr/write_data/write_ack  register-file write port driven from the queue head
//   byp_addr/byp_hit/byp_data  forwarding lookup over pending writes (youngest match wins)
//   count             number of pending writes
module writeback_queue #(
    parameter int W           = 32,
    parameter int RA_W        = 5,
    parameter int DEPTH       = 2,
    parameter int SRC_W       = 2,
    parameter int LINK_OFFSET = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_reg_write,
    input  logic [RA_W-1:0]          in_rd,
    input  logic [SRC_W-1:0]         in_src,
    input  logic [W-1:0]             in_alu,
    input  logic [W-1:0]             in_mem,
    input  logic [W-1:0]             in_pc,
    input  logic [W-1:0]             in_imm,
    input  logic [1:0]               in_msize,
    input  logic                     in_munsigned,
    input  logic [1:0]               in_boff,
    output logic                     write_en,
    output logic [RA_W-1:0]          write_addr,
    output logic [W-1:0]             write_data,
    input  logic                     write_ack,
    input  logic [RA_W-1:0]          byp_addr,
    output logic                     byp_hit,
    output logic [W-1:0]             byp_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [RA_W-1:0] ent_rd  [DEPTH];
    logic [W-1:0]    ent_dat [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   occ;

    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;

    assign full     = (occ == CW'(DEPTH));
    assign empty    = (occ == '0);
    // Full is decided from registered occupancy only, so write_ack never reaches in_ready.
    assign in_ready = !full;
    // Writes without a destination, or to the hard-wired zero register, are consumed silently.
    assign enq      = in_valid && in_ready && in_reg_write && (in_rd != '0);
    assign deq      = !empty && write_ack;

    // Load alignment: byte lane chosen by the full offset, half lane by offset bit 1 only.
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic         sext;
    logic [W-1:0] mem_val;
    logic [W-1:0] sel_dat;

    assign ld_byte = in_mem[{in_boff, 3'b000} +: 8];
    assign ld_half = in_mem[{in_boff[1], 4'b0000} +: 16];
    assign sext    = !in_munsigned;

    always_comb begin
        mem_val = in_mem;
        case (in_msize)
            2'd0:    mem_val = {{(W-8){sext & ld_byte[7]}}, ld_byte};
            2'd1:    mem_val = {{(W-16){sext & ld_half[15]}}, ld_half};
            default: mem_val = in_mem;
        endcase
    end

    always_comb begin
        sel_dat = in_alu;
        if (in_src == SRC_W'(1))
            sel_dat = mem_val;
        else if (in_src == SRC_W'(2))
            sel_dat = in_pc + W'(LINK_OFFSET);
        else if (in_src == SRC_W'(3))
            sel_dat = in_imm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i]  <= '0;
                ent_dat[i] <= '0;
            end
        end else begin
            if (enq) begin
                ent_rd[tail]  <= in_rd;
                ent_dat[tail] <= sel_dat;
                tail          <= tail + PW'(1);
            end
            if (deq)
                head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Dequeued slots keep stale contents, so the head is masked when the queue is empty.
    assign write_en   = !empty;
    assign write_addr = empty ? '0 : ent_rd[head];
    assign write_data = empty ? '0 : ent_dat[head];
    assign count      = occ;

    // Walk from oldest to youngest so the last match seen is the youngest pending write.
    logic [PW-1:0] byp_idx;
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx = head + PW'(k);
            if ((CW'(k) < occ) && (byp_addr != '0) && (ent_rd[byp_idx] == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = ent_dat[byp_idx];
            end
        end
    end
endmodule
